// File: rtl/tt_pkg.sv
// Shared constants and types for the character-terminal engine.
package tt_pkg;

  // Control codes interpreted by the engine
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  // Writer FSM states
  typedef enum logic [1:0] {
    ST_CLEAR_ALL = 2'd0,
    ST_IDLE      = 2'd1,
    ST_WRITE     = 2'd2,
    ST_CLEAR_ROW = 2'd3
  } tt_state_e;

  // Codes at or above SPACE are glyphs; anything below is a control code
  function automatic logic is_glyph(input logic [7:0] code);
    return code >= CH_SPACE;
  endfunction

endpackage

// File: rtl/text_term_ctrl_if.sv
// Byte-stream input and display read port of the terminal engine.
//
// Handshake: a byte transfers on a rising clock edge where in_valid && in_ready.
// The source holds in_data stable while in_valid is high and in_ready is low;
// in_ready does not depend on in_valid. After a transfer the byte is owned by
// the engine and in_data may change on the next cycle.
// Read port: rd_char reflects (rd_col, rd_row) presented one cycle earlier.
interface text_term_ctrl_if #(
  parameter int COLS = 80,
  parameter int ROWS = 30
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] rd_col;
  logic [RW-1:0] rd_row;
  logic [7:0]    rd_char;

  modport master (
    output in_data, in_valid, rd_col, rd_row,
    input  in_ready, rd_char
  );

  modport slave (
    input  in_data, in_valid, rd_col, rd_row,
    output in_ready, rd_char
  );
endinterface

// File: rtl/tt_char_ram.sv
// Simple dual-port character RAM: one write port, one registered read port.
// A read of the cell written in the same cycle returns the previous contents.
module tt_char_ram #(
  parameter int DEPTH = 2400,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port, cleared by reset so the display sees 0 until the first read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_term_ctrl.sv
// Character-terminal engine: interprets a byte stream, writes glyphs into a
// COLS x ROWS ring-buffered character RAM and serves a 1-cycle display read
// port with a blinking cursor overlay.
module text_term_ctrl
  import tt_pkg::*;
#(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 30,
  parameter int         TAB_W      = 8,
  parameter int         BLINK_BITS = 23,
  parameter logic [7:0] CLR_CHAR   = 8'h20,
  parameter logic [7:0] CUR_CHAR   = 8'h5F,
  localparam int        CW         = $clog2(COLS),
  localparam int        RW         = $clog2(ROWS)
) (
  input  logic              clk_25mhz,
  input  logic              rst,
  text_term_ctrl_if.slave   term,
  output logic [CW-1:0]     cur_col,
  output logic [RW-1:0]     cur_row,
  output logic              busy,
  output tt_state_e         fsm_state
);

  localparam int            CELLS    = COLS * ROWS;
  localparam int            AW       = $clog2(CELLS);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW:0]   TAB_MASK = (CW+1)'(TAB_W - 1);

  // Screen row -> physical row through the ring base, compare-and-subtract wrap
  function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] row,
                                             input logic [RW-1:0] base);
    logic [RW:0] sum;
    sum = {1'b0, row} + {1'b0, base};
    if (sum >= (RW+1)'(ROWS)) sum = sum - (RW+1)'(ROWS);
    return sum[RW-1:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] prow,
                                              input logic [CW-1:0] col);
    return AW'(prow) * AW'(COLS) + AW'(col);
  endfunction

  tt_state_e       state, state_next;
  logic [CW-1:0]   cur_col_q;
  logic [RW-1:0]   cur_row_q, base_q;
  logic [AW-1:0]   sweep_q;
  logic [7:0]      byte_q;
  logic            ready, accept;
  logic [RW-1:0]   nl_row, nl_base;
  logic [CW-1:0]   tab_col;
  logic            ram_we;
  logic [AW-1:0]   ram_waddr, ram_raddr;
  logic [7:0]      ram_wdata, ram_rdata;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic            blink;
  logic            rd_oob, rd_oob_q;
  logic [CW-1:0]   rd_col_q;
  logic [RW-1:0]   rd_row_q;

  assign accept    = term.in_valid && ready;
  assign fsm_state = state;
  assign cur_col   = cur_col_q;
  assign cur_row   = cur_row_q;
  assign term.in_ready = ready;

  // FSM state register; reset always restarts the full clear
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) state <= ST_CLEAR_ALL;
    else     state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_CLEAR_ALL: if (sweep_q == AW'(CELLS - 1)) state_next = ST_IDLE;
      ST_IDLE: begin
        if (accept) begin
          if (term.in_data == CH_FF)                              state_next = ST_CLEAR_ALL;
          else if (term.in_data == CH_LF && cur_row_q == LAST_ROW) state_next = ST_CLEAR_ROW;
          else if (is_glyph(term.in_data))                        state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (cur_col_q == LAST_COL && cur_row_q == LAST_ROW) state_next = ST_CLEAR_ROW;
        else                                                state_next = ST_IDLE;
      end
      ST_CLEAR_ROW: if (sweep_q == AW'(COLS - 1)) state_next = ST_IDLE;
      default: state_next = ST_CLEAR_ALL;
    endcase
  end

  // FSM outputs: RAM write port, handshake and busy flag
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = CLR_CHAR;
    ready     = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_CLEAR_ALL: begin
        ram_we    = 1'b1;
        ram_waddr = sweep_q;
        busy      = 1'b1;
      end
      ST_IDLE: ready = 1'b1;
      ST_WRITE: begin
        ram_we    = 1'b1;
        ram_waddr = cell_addr(phys_row(cur_row_q, base_q), cur_col_q);
        ram_wdata = byte_q;
      end
      ST_CLEAR_ROW: begin
        // base has already advanced, so screen row ROWS-1 is the recycled row
        ram_we    = 1'b1;
        ram_waddr = cell_addr(phys_row(LAST_ROW, base_q), '0) + sweep_q;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Newline target: step down a row, or scroll by advancing the ring base
  always_comb begin
    nl_row  = cur_row_q;
    nl_base = base_q;
    if (cur_row_q != LAST_ROW) nl_row  = cur_row_q + 1'b1;
    else if (base_q == LAST_ROW) nl_base = '0;
    else                         nl_base = base_q + 1'b1;
  end

  // Next tab stop, clamped to the last column
  always_comb begin
    logic [CW:0] t;
    t = ({1'b0, cur_col_q} | TAB_MASK) + (CW+1)'(1);
    if (t > {1'b0, LAST_COL}) tab_col = LAST_COL;
    else                      tab_col = t[CW-1:0];
  end

  // Sweep counter restarts on every state change and runs during clears
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst)                      sweep_q <= '0;
    else if (state_next != state) sweep_q <= '0;
    else if (busy)                sweep_q <= sweep_q + 1'b1;
  end

  // Cursor, ring base and latched byte
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      cur_col_q <= '0;
      cur_row_q <= '0;
      base_q    <= '0;
      byte_q    <= '0;
    end else begin
      case (state)
        ST_CLEAR_ALL: begin
          if (state_next == ST_IDLE) begin
            cur_col_q <= '0;
            cur_row_q <= '0;
            base_q    <= '0;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            byte_q <= term.in_data;
            case (term.in_data)
              CH_CR:  cur_col_q <= '0;
              CH_LF:  begin cur_row_q <= nl_row; base_q <= nl_base; end
              CH_BS:  if (cur_col_q != '0) cur_col_q <= cur_col_q - 1'b1;
              CH_TAB: cur_col_q <= tab_col;
              default: ;
            endcase
          end
        end
        ST_WRITE: begin
          if (cur_col_q != LAST_COL) begin
            cur_col_q <= cur_col_q + 1'b1;
          end else begin
            cur_col_q <= '0;
            cur_row_q <= nl_row;
            base_q    <= nl_base;
          end
        end
        default: ;
      endcase
    end
  end

  // Free-running blink divider; phase flips each time the counter wraps
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
      if (&blink_cnt) blink <= ~blink;
    end
  end

  // Display read address; out-of-range coordinates read cell 0 and are masked later
  always_comb begin
    rd_oob    = ({1'b0, term.rd_col} >= (CW+1)'(COLS)) ||
                ({1'b0, term.rd_row} >= (RW+1)'(ROWS));
    ram_raddr = rd_oob ? '0 : cell_addr(phys_row(term.rd_row, base_q), term.rd_col);
  end

  // Pipeline read coordinates to line up with the RAM read latency
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      rd_col_q <= '0;
      rd_row_q <= '0;
      rd_oob_q <= 1'b0;
    end else begin
      rd_col_q <= term.rd_col;
      rd_row_q <= term.rd_row;
      rd_oob_q <= rd_oob;
    end
  end

  // Output mux: out-of-range fill, cursor overlay, else RAM data
  always_comb begin
    if (rd_oob_q)
      term.rd_char = CLR_CHAR;
    else if (blink && rd_col_q == cur_col_q && rd_row_q == cur_row_q)
      term.rd_char = CUR_CHAR;
    else
      term.rd_char = ram_rdata;
  end

  tt_char_ram #(.DEPTH(CELLS), .AW(AW)) u_ram (
    .clk   (clk_25mhz),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_text_term_ctrl.sv
// Directed bench for the character-terminal engine (80x30, fast blink).
module tb_text_term_ctrl;
  import tt_pkg::*;

  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int N    = COLS * ROWS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] cur_col;
  logic [4:0] cur_row;
  logic       busy;
  tt_state_e  fsm_state;
  int         errors = 0;
  int         checks = 0;

  text_term_ctrl_if #(.COLS(COLS), .ROWS(ROWS)) term ();

  text_term_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .TAB_W(8), .BLINK_BITS(4),
    .CLR_CHAR(8'h20), .CUR_CHAR(8'h5F)
  ) dut (
    .clk_25mhz (clk),
    .rst       (rst),
    .term      (term),
    .cur_col   (cur_col),
    .cur_row   (cur_row),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  // Clock and safety net
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and return 1 ns after the edge that transferred it
  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    term.in_data  = b;
    term.in_valid = 1'b1;
    while (!term.in_ready && w < 5000) begin tick(); w++; end
    if (!term.in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout byte %h: in_ready got 0 required 1", b);
    end
    tick();
    term.in_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!term.in_ready && w < 5000) begin tick(); w++; end
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 5000) begin tick(); cycles++; end
  endtask

  task automatic read_cell(input int c, input int r, output logic [7:0] v);
    term.rd_col = 7'(c);
    term.rd_row = 5'(r);
    tick();
    v = term.rd_char;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    int n;
    rst = 1'b1;
    term.in_valid = 1'b0; term.in_data = 8'h00;
    term.rd_col = '0; term.rd_row = '0;
    repeat (3) tick();
    checks++; if (term.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b required 0", term.in_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b required 1", busy); end
    checks++; if (term.rd_char !== 8'h00) begin errors++; $display("FAIL rst_rd_char got %h required 00", term.rd_char); end
    checks++; if (cur_col !== 7'd0 || cur_row !== 5'd0) begin errors++; $display("FAIL rst_cursor got (%0d,%0d) required (0,0)", cur_col, cur_row); end
    checks++; if (fsm_state !== ST_CLEAR_ALL) begin errors++; $display("FAIL rst_state got %0d required %0d", fsm_state, ST_CLEAR_ALL); end
    rst = 1'b0;
    wait_idle(n);
    checks++; if (n != N) begin errors++; $display("FAIL clear_all_cycles got %0d required %0d", n, N); end
    checks++; if (term.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b required 1", term.in_ready); end
    checks++; if (cur_col !== 7'd0 || cur_row !== 5'd0) begin errors++; $display("FAIL clear_cursor got (%0d,%0d) required (0,0)", cur_col, cur_row); end
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (c == 0 && r == 0) continue;
        read_cell(c, r, v);
        checks++; if (v !== 8'h20) begin errors++; $display("FAIL cleared_cell (%0d,%0d) got %h required 20", c, r, v); end
      end
    end
  endtask

  task automatic test_write_ab();
    logic [7:0] v;
    logic [7:0] msg [2];
    msg[0] = 8'h41; msg[1] = 8'h42;
    for (int i = 0; i < 2; i++) begin
      send_byte(msg[i]);
      checks++; if (term.in_ready !== 1'b0 || fsm_state !== ST_WRITE) begin errors++; $display("FAIL write_ready_low byte %0d got ready=%b state=%0d required 0/WRITE", i, term.in_ready, fsm_state); end
      tick();
      checks++; if (term.in_ready !== 1'b1) begin errors++; $display("FAIL write_ready_back byte %0d got %b required 1", i, term.in_ready); end
    end
    read_cell(0, 0, v);
    checks++; if (v !== 8'h41) begin errors++; $display("FAIL ab_cell0 got %h required 41", v); end
    read_cell(1, 0, v);
    checks++; if (v !== 8'h42) begin errors++; $display("FAIL ab_cell1 got %h required 42", v); end
    checks++; if (cur_col !== 7'd2 || cur_row !== 5'd0) begin errors++; $display("FAIL ab_cursor got (%0d,%0d) required (2,0)", cur_col, cur_row); end
  endtask

  task automatic test_line_wrap();
    logic [7:0] v;
    send_byte(CH_CR);
    checks++; if (cur_col !== 7'd0) begin errors++; $display("FAIL cr_col got %0d required 0", cur_col); end
    for (int i = 0; i < 81; i++) send_byte(8'h78);
    wait_ready();
    checks++; if (cur_col !== 7'd1 || cur_row !== 5'd1) begin errors++; $display("FAIL wrap_cursor got (%0d,%0d) required (1,1)", cur_col, cur_row); end
    for (int c = 0; c < COLS; c++) begin
      read_cell(c, 0, v);
      checks++; if (v !== 8'h78) begin errors++; $display("FAIL wrap_row0 col %0d got %h required 78", c, v); end
    end
    read_cell(0, 1, v);
    checks++; if (v !== 8'h78) begin errors++; $display("FAIL wrap_81st got %h required 78", v); end
    read_cell(2, 1, v);
    checks++; if (v !== 8'h20) begin errors++; $display("FAIL wrap_after got %h required 20", v); end
    read_cell(80, 0, v);
    checks++; if (v !== 8'h20) begin errors++; $display("FAIL oob_col got %h required 20", v); end
    read_cell(0, 31, v);
    checks++; if (v !== 8'h20) begin errors++; $display("FAIL oob_row got %h required 20", v); end
    read_cell(127, 30, v);
    checks++; if (v !== 8'h20) begin errors++; $display("FAIL oob_both got %h required 20", v); end
  endtask

  task automatic test_scroll();
    logic [7:0] v;
    int n;
    for (int i = 0; i < 28; i++) send_byte(CH_LF);
    checks++; if (cur_row !== 5'd29 || cur_col !== 7'd1) begin errors++; $display("FAIL lf_cursor got (%0d,%0d) required (1,29)", cur_col, cur_row); end
    send_byte(8'h5A);
    wait_ready();
    send_byte(CH_LF);
    wait_idle(n);
    checks++; if (n != COLS) begin errors++; $display("FAIL scroll_cycles got %0d required %0d", n, COLS); end
    checks++; if (cur_row !== 5'd29 || cur_col !== 7'd2) begin errors++; $display("FAIL scroll_cursor got (%0d,%0d) required (2,29)", cur_col, cur_row); end
    read_cell(0, 0, v);
    checks++; if (v !== 8'h78) begin errors++; $display("FAIL scroll_row0_col0 got %h required 78", v); end
    read_cell(1, 0, v);
    checks++; if (v !== 8'h20) begin errors++; $display("FAIL scroll_row0_col1 got %h required 20", v); end
    read_cell(1, 28, v);
    checks++; if (v !== 8'h5A) begin errors++; $display("FAIL scroll_row28 got %h required 5a", v); end
    for (int c = 0; c < COLS; c++) begin
      if (c == 2) continue;
      read_cell(c, 29, v);
      checks++; if (v !== 8'h20) begin errors++; $display("FAIL scroll_row29 col %0d got %h required 20", c, v); end
    end
  endtask

  task automatic test_cursor_ctrl();
    logic [7:0] v;
    logic [7:0] seq [4];
    logic [6:0] exp_col [4];
    send_byte(CH_CR);
    send_byte(CH_TAB);
    repeat (3) send_byte(CH_BS);
    checks++; if (cur_col !== 7'd5) begin errors++; $display("FAIL ctrl_start got %0d required 5", cur_col); end
    seq[0] = CH_TAB; seq[1] = CH_BS; seq[2] = CH_BS; seq[3] = CH_CR;
    exp_col[0] = 7'd8; exp_col[1] = 7'd7; exp_col[2] = 7'd6; exp_col[3] = 7'd0;
    for (int i = 0; i < 4; i++) begin
      send_byte(seq[i]);
      checks++; if (cur_col !== exp_col[i] || term.in_ready !== 1'b1) begin errors++; $display("FAIL ctrl_step %0d got col=%0d ready=%b required col=%0d ready=1", i, cur_col, term.in_ready, exp_col[i]); end
    end
    send_byte(CH_BS);
    checks++; if (cur_col !== 7'd0) begin errors++; $display("FAIL bs_at_zero got %0d required 0", cur_col); end
    send_byte(8'h01);
    checks++; if (cur_col !== 7'd0 || term.in_ready !== 1'b1) begin errors++; $display("FAIL dropped_code got col=%0d ready=%b required 0/1", cur_col, term.in_ready); end
    repeat (10) send_byte(CH_TAB);
    checks++; if (cur_col !== 7'd79) begin errors++; $display("FAIL tab_clamp got %0d required 79", cur_col); end
    send_byte(CH_BS);
    send_byte(CH_TAB);
    checks++; if (cur_col !== 7'd79 || cur_row !== 5'd29) begin errors++; $display("FAIL tab_from_78 got (%0d,%0d) required (79,29)", cur_col, cur_row); end
    for (int c = 0; c < COLS - 1; c++) begin
      read_cell(c, 29, v);
      checks++; if (v !== 8'h20) begin errors++; $display("FAIL ctrl_no_write col %0d got %h required 20", c, v); end
    end
    send_byte(CH_CR);
  endtask

  task automatic test_form_feed();
    logic [7:0] v;
    int n;
    send_byte(CH_FF);
    wait_idle(n);
    checks++; if (n != N) begin errors++; $display("FAIL ff_cycles got %0d required %0d", n, N); end
    checks++; if (cur_col !== 7'd0 || cur_row !== 5'd0) begin errors++; $display("FAIL ff_cursor got (%0d,%0d) required (0,0)", cur_col, cur_row); end
    read_cell(1, 28, v);
    checks++; if (v !== 8'h20) begin errors++; $display("FAIL ff_row28 got %h required 20", v); end
    read_cell(1, 0, v);
    checks++; if (v !== 8'h20) begin errors++; $display("FAIL ff_row0 got %h required 20", v); end
  endtask

  task automatic test_blink();
    logic [7:0] s [64];
    term.rd_col = '0;
    term.rd_row = '0;
    tick();
    for (int i = 0; i < 64; i++) begin
      s[i] = term.rd_char;
      tick();
    end
    for (int i = 0; i < 64; i++) begin
      checks++; if (s[i] !== 8'h5F && s[i] !== 8'h20) begin errors++; $display("FAIL blink_value sample %0d got %h required 5f or 20", i, s[i]); end
    end
    for (int i = 0; i < 48; i++) begin
      checks++; if (s[i] === s[i+16]) begin errors++; $display("FAIL blink_period sample %0d got %h and %h required different", i, s[i], s[i+16]); end
    end
  endtask

  task automatic test_reset_mid_scroll();
    logic [7:0] v;
    int n;
    repeat (10) send_byte(CH_LF);
    send_byte(8'h51);
    wait_ready();
    repeat (19) send_byte(CH_LF);
    send_byte(CH_LF);
    repeat (10) tick();
    checks++; if (busy !== 1'b1 || fsm_state !== ST_CLEAR_ROW) begin errors++; $display("FAIL mid_scroll got busy=%b state=%0d required 1/CLEAR_ROW", busy, fsm_state); end
    rst = 1'b1;
    repeat (2) tick();
    checks++; if (busy !== 1'b1 || term.in_ready !== 1'b0 || term.rd_char !== 8'h00) begin errors++; $display("FAIL mid_rst got busy=%b ready=%b rd=%h required 1/0/00", busy, term.in_ready, term.rd_char); end
    rst = 1'b0;
    wait_idle(n);
    checks++; if (n != N) begin errors++; $display("FAIL mid_rst_cycles got %0d required %0d", n, N); end
    checks++; if (cur_col !== 7'd0 || cur_row !== 5'd0) begin errors++; $display("FAIL mid_rst_cursor got (%0d,%0d) required (0,0)", cur_col, cur_row); end
    read_cell(0, 9, v);
    checks++; if (v !== 8'h20) begin errors++; $display("FAIL mid_rst_row9 got %h required 20", v); end
    read_cell(0, 10, v);
    checks++; if (v !== 8'h20) begin errors++; $display("FAIL mid_rst_row10 got %h required 20", v); end
    send_byte(8'h52);
    wait_ready();
    read_cell(0, 0, v);
    checks++; if (v !== 8'h52) begin errors++; $display("FAIL post_rst_write got %h required 52", v); end
  endtask

  initial begin
    test_reset();
    test_write_ab();
    test_line_wrap();
    test_scroll();
    test_cursor_ctrl();
    test_form_feed();
    test_blink();
    test_reset_mid_scroll();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
